sm_bus_arbiter: RTL

- Two-master arbiter for the data-memory bus in front of the RAM/hex-display address decoder.
- Master 0 is the CPU data port; master 1 is the program loader / debug port.
- Grants one bus beat per cycle with round-robin fairness and a bounded locked burst.
- Drives the decoder's address, write-enable and write-data inputs and returns registered read data to the winning master.

---
 rtl/sm_bus_pkg.sv | 18 +
 rtl/sm_bus_arbiter_rr_pick.sv | 14 +
 rtl/sm_bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sm_bus_pkg.sv
// Shared types and default sizes for the two-master data-memory bus arbiter.
package sm_bus_pkg;

  localparam int SM_BUS_ADDR_W    = 32;
  localparam int SM_BUS_DATA_W    = 32;
  localparam int SM_BUS_MAX_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  // 1-bit master index used for `last` and the picker result
  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

endpackage

// File: rtl/sm_bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last goes.
module sm_rr_pick (
  input  logic [1:0] eff,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |eff;
    winner = (eff == 2'b11) ? ~last : eff[1];
  end

endmodule

// File: rtl/sm_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory bus with bounded locked bursts
// and registered per-master read data return.
module sm_bus_arbiter
  import sm_bus_pkg::*;
#(
  parameter int ADDR_W    = SM_BUS_ADDR_W,
  parameter int DATA_W    = SM_BUS_DATA_W,
  parameter int MAX_BURST = SM_BUS_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dataMemory_address,
  output logic              dataMemory_writeEnable,
  output logic [DATA_W-1:0] dataMemory_writeData,
  input  logic [DATA_W-1:0] dataMemory_readData
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

  owner_t            owner_q, owner_d;
  logic              last_q, last_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0] eff;
  logic       pick_valid, pick_winner;
  logic       stay;

  // The owner only keeps competing while it signals lock; a plain req is its finished beat.
  assign eff[0] = (owner_q == OWN_M0) ? (m0_req & m0_lock) : m0_req;
  assign eff[1] = (owner_q == OWN_M1) ? (m1_req & m1_lock) : m1_req;

  sm_rr_pick u_pick (
    .eff    (eff),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    stay = 1'b0;
    unique case (owner_q)
      OWN_M0:  stay = eff[0] & (~m1_req | (burst_cnt_q < BURST_LIM));
      OWN_M1:  stay = eff[1] & (~m0_req | (burst_cnt_q < BURST_LIM));
      default: stay = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      owner_q     <= OWN_NONE;
      last_q      <= SEL_M1;
      burst_cnt_q <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state decision
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (stay) begin
      burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
    end else begin
      if (pick_valid) begin
        owner_d = (pick_winner == SEL_M1) ? OWN_M1 : OWN_M0;
        last_d  = pick_winner;
      end else begin
        owner_d = OWN_NONE;
      end
      if (owner_d != owner_q) burst_cnt_d = 8'd0;
    end
  end

  // Grant and bus outputs straight from the owner register
  always_comb begin
    m0_gnt                 = 1'b0;
    m1_gnt                 = 1'b0;
    dataMemory_address     = '0;
    dataMemory_writeEnable = 1'b0;
    dataMemory_writeData   = '0;
    unique case (owner_q)
      OWN_M0: begin
        m0_gnt                 = 1'b1;
        dataMemory_address     = m0_addr;
        dataMemory_writeEnable = m0_we;
        dataMemory_writeData   = m0_wdata;
      end
      OWN_M1: begin
        m1_gnt                 = 1'b1;
        dataMemory_address     = m1_addr;
        dataMemory_writeEnable = m1_we;
        dataMemory_writeData   = m1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rvalid0_d = (owner_q == OWN_M0) & ~m0_we;
    rvalid1_d = (owner_q == OWN_M1) & ~m1_we;
    rdata0_d  = rvalid0_d ? dataMemory_readData : rdata0_q;
    rdata1_d  = rvalid1_d ? dataMemory_readData : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule
